// File: rtl/lane_serializer.sv
`default_nettype none
// ============================================================================
// Module   : lane_serializer
// Brief    : Splits a DATA_W-bit word into LANE_W-bit lanes emitted one per
//            cycle, LSB- or MSB-first, over valid/ready handshakes.
//            Optional macro LANE_SER_PIPE_EN: accept the next word on the
//            last beat for bubble-free back-to-back words.
// Revision : 1.0 - initial release
// ============================================================================
module lane_serializer #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    localparam int N_LANES = DATA_W / LANE_W,
    localparam int IDX_W   = $clog2(N_LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_count,
    input  logic              in_msb_first,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [0:0]       c_idle    = 1'b0;
    localparam logic [0:0]       c_send    = 1'b1;
    localparam logic [IDX_W-1:0] c_max_idx = IDX_W'(N_LANES - 1);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_count;
    logic              r_msb;

    logic                           w_out_fire;
    logic                           w_in_fire;
    logic [IDX_W-1:0]               w_count_in;
    logic [IDX_W-1:0]               w_first_idx;
    logic [IDX_W-1:0]               w_next_idx;
    logic                           w_next_last;
    logic [N_LANES-1:0][LANE_W-1:0] w_in_lanes;
    logic [N_LANES-1:0][LANE_W-1:0] w_word_lanes;

    assign w_in_lanes   = in_data;
    assign w_word_lanes = r_word;

    assign out_valid  = (r_state == c_send);
    assign busy       = (r_state == c_send);
    assign w_out_fire = out_valid && out_ready;

`ifdef LANE_SER_PIPE_EN
    // The last beat frees the holding register on the same edge it leaves.
    assign in_ready = (r_state == c_idle) || (w_out_fire && out_last);
`else
    assign in_ready = (r_state == c_idle);
`endif

    assign w_in_fire = in_valid && in_ready;

    // Clamp keeps the lane index in range when N_LANES is not a power of two.
    assign w_count_in  = (in_count > c_max_idx) ? c_max_idx : in_count;
    assign w_first_idx = in_msb_first ? w_count_in : '0;

    assign w_next_idx  = r_msb ? (out_idx - 1'b1) : (out_idx + 1'b1);
    assign w_next_last = r_msb ? (w_next_idx == '0) : (w_next_idx == r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_word   <= '0;
            r_count  <= '0;
            r_msb    <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (w_in_fire) begin
            r_state  <= c_send;
            r_word   <= in_data;
            r_count  <= w_count_in;
            r_msb    <= in_msb_first;
            out_data <= w_in_lanes[w_first_idx];
            out_idx  <= w_first_idx;
            out_last <= (w_count_in == '0);
        end else if (w_out_fire) begin
            if (out_last) begin
                r_state  <= c_idle;
                out_last <= 1'b0;
            end else begin
                out_data <= w_word_lanes[w_next_idx];
                out_idx  <= w_next_idx;
                out_last <= w_next_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_serializer
// Brief    : Self-checking bench for lane_serializer (32/8 and 64/16 builds)
//            against a lane-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_serializer;

`ifdef LANE_SER_PIPE_EN
    localparam bit c_pipe = 1'b1;
`else
    localparam bit c_pipe = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_in_data;
    logic [1:0]  a_in_count;
    logic        a_in_msb, a_in_valid, a_in_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_idx;
    logic        a_out_last, a_out_valid, a_out_ready, a_busy;

    logic [63:0] b_in_data;
    logic [1:0]  b_in_count;
    logic        b_in_msb, b_in_valid, b_in_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_idx;
    logic        b_out_last, b_out_valid, b_out_ready, b_busy;

    lane_serializer #(.DATA_W(32), .LANE_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_count(a_in_count), .in_msb_first(a_in_msb),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy)
    );

    lane_serializer #(.DATA_W(64), .LANE_W(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_count(b_in_count), .in_msb_first(b_in_msb),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
    );

    typedef struct {logic [63:0] data; int count; bit msb;} word_t;
    typedef struct {logic [15:0] data; int idx; bit last;} lane_t;

    word_t offer_q[$];
    lane_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lane sequence straight from the word: lane i = bits [i*W +: W].
    function automatic void expect_word(input word_t w, input int lane_w);
        for (int j = 0; j <= w.count; j++) begin
            lane_t l;
            int    i;
            i      = w.msb ? (w.count - j) : j;
            l.data = 16'((w.data >> (lane_w * i)) & ((64'd1 << lane_w) - 64'd1));
            l.idx  = i;
            l.last = (j == w.count);
            sb_q.push_back(l);
        end
    endfunction

    function automatic word_t mk_word(input logic [63:0] d, input int k, input bit m);
        word_t w;
        w.data = d; w.count = k; w.msb = m;
        return w;
    endfunction

    function automatic word_t junk_word();
        return mk_word({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom));
    endfunction

    task automatic drive(input bit sel, input bit v, input word_t w, input bit rdy);
        if (sel) begin
            b_in_valid = v; b_in_data = w.data; b_in_count = 2'(w.count);
            b_in_msb = w.msb; b_out_ready = rdy;
        end else begin
            a_in_valid = v; a_in_data = w.data[31:0]; a_in_count = 2'(w.count);
            a_in_msb = w.msb; a_out_ready = rdy;
        end
    endtask

    // Offers every queued word (in_valid held while the queue is non-empty)
    // and checks every cycle against the scoreboard until both drain.
    task automatic run(input bit sel, input bit rand_ready, input int lane_w);
        int    cyc = 0;
        bit    v, rdy, exp_rdy, o_valid, o_busy, o_inrdy, o_last;
        word_t w;
        logic [15:0] o_data;
        int    o_idx;
        while ((offer_q.size() > 0 || sb_q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            v   = (offer_q.size() > 0);
            w   = v ? offer_q[0] : junk_word();
            rdy = rand_ready ? 1'($urandom) : 1'b1;
            drive(sel, v, w, rdy);
            #1;
            o_valid = sel ? b_out_valid : a_out_valid;
            o_busy  = sel ? b_busy      : a_busy;
            o_inrdy = sel ? b_in_ready  : a_in_ready;
            o_data  = sel ? b_out_data  : {8'h00, a_out_data};
            o_idx   = sel ? int'(b_out_idx) : int'(a_out_idx);
            o_last  = sel ? b_out_last  : a_out_last;
            exp_rdy = (sb_q.size() == 0) || (c_pipe && sb_q.size() == 1 && rdy);
            check("out_valid", 64'(o_valid), 64'(sb_q.size() > 0));
            check("busy", 64'(o_busy), 64'(sb_q.size() > 0));
            check("in_ready", 64'(o_inrdy), 64'(exp_rdy));
            if (sb_q.size() > 0) begin
                check("out_data", 64'(o_data), 64'(sb_q[0].data));
                check("out_idx", 64'(o_idx), 64'(sb_q[0].idx));
                check("out_last", 64'(o_last), 64'(sb_q[0].last));
                if (rdy) void'(sb_q.pop_front());
            end
            if (v && exp_rdy) begin
                void'(offer_q.pop_front());
                expect_word(w, lane_w);
            end
            cyc++;
        end
        if (cyc >= 2000) check("timeout", 64'd0, 64'd1);
        @(negedge clk);
        drive(sel, 1'b0, junk_word(), 1'b0);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        drive(1'b0, 1'b0, junk_word(), 1'b0);
        drive(1'b1, 1'b0, junk_word(), 1'b0);
        repeat (2) @(negedge clk);
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_data", 64'(a_out_data), 64'd0);
        check("rst_a_idx", 64'(a_out_idx), 64'd0);
        check("rst_a_last", 64'(a_out_last), 64'd0);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        rst = 1'b0;

        // LSB-first full word, then MSB-first two lanes.
        offer_q.push_back(mk_word(64'h11223344, 3, 1'b0));
        run(1'b0, 1'b0, 8);
        offer_q.push_back(mk_word(64'h11223344, 1, 1'b1));
        run(1'b0, 1'b0, 8);
        // Random backpressure.
        offer_q.push_back(mk_word(64'h11223344, 3, 1'b0));
        run(1'b0, 1'b1, 8);
        // Back-to-back words with in_valid held high.
        offer_q.push_back(mk_word(64'h11223344, 3, 1'b0));
        offer_q.push_back(mk_word(64'h55667788, 2, 1'b1));
        offer_q.push_back(mk_word(64'h99AABBCC, 0, 1'b0));
        run(1'b0, 1'b0, 8);

        // Reset while lane 2 is presented.
        @(negedge clk);
        drive(1'b0, 1'b1, mk_word(64'h11223344, 3, 1'b0), 1'b1);
        waited = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 1'b0, junk_word(), 1'b1);
            #1;
            waited++;
        end while (!(a_out_valid && a_out_idx == 2'd2) && waited < 10);
        if (waited >= 10) check("wait_idx2", 64'd0, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(a_out_valid), 64'd0);
        check("midrst_in_ready", 64'(a_in_ready), 64'd1);
        check("midrst_data", 64'(a_out_data), 64'd0);
        check("midrst_idx", 64'(a_out_idx), 64'd0);
        check("midrst_busy", 64'(a_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        offer_q.push_back(mk_word(64'hAABBCCDD, 3, 1'b0));
        run(1'b0, 1'b0, 8);

        // Random words, random ordering and counts, random backpressure.
        for (int n = 0; n < 20; n++)
            offer_q.push_back(mk_word({32'h0, $urandom}, int'($urandom_range(0, 3)), 1'($urandom)));
        run(1'b0, 1'b1, 8);
        for (int n = 0; n < 8; n++)
            offer_q.push_back(mk_word({32'h0, $urandom}, int'($urandom_range(0, 3)), 1'($urandom)));
        run(1'b0, 1'b0, 8);

        // Wide build: 64-bit word in 16-bit lanes.
        offer_q.push_back(mk_word(64'h0123456789ABCDEF, 3, 1'b0));
        run(1'b1, 1'b0, 16);
        for (int n = 0; n < 10; n++)
            offer_q.push_back(mk_word({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom)));
        run(1'b1, 1'b1, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
